booth_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit signed Booth multiplier unit among NREQ requesters.
- Accepts a request, latches its operands and issues a single-cycle start to the multiplier.
- Holds the operands stable while the multiplier runs, captures its result on valid and returns it to the owner with a done pulse.
- A watchdog timer aborts a hung multiplication and flags an error.

---
 rtl/booth_mul_arbiter_if.sv | 33 +++
 rtl/booth_mul_arbiter.sv | 143 ++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Requester and multiplier signals of the Booth multiplier arbiter, bundled for port hookup.
// slave is the arbiter side; master is the requesters plus the multiplier.
interface booth_mul_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    result;
  logic              err;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic              mul_valid;
  logic [2*W-1:0]    mul_z;
  logic              mul_rst_n;

  modport slave (
    input  req, req_x, req_y, mul_valid, mul_z,
    output ack, done, result, err, busy, mul_start, mul_x, mul_y, mul_rst_n
  );

  modport master (
    output req, req_x, req_y, mul_valid, mul_z,
    input  ack, done, result, err, busy, mul_start, mul_x, mul_y, mul_rst_n
  );

endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that shares one signed Booth multiplier among NREQ requesters,
// with a watchdog that aborts a multiplication that never reports valid.
module booth_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic [TmrW-1:0]     timer_q;
  logic [NREQ-1:0]     ack_q;
  logic [NREQ-1:0]     done_q;
  logic [2*W-1:0]      result_q;
  logic                err_q;
  logic                busy_q;
  logic                mul_start_q;
  logic [W-1:0]        mul_x_q;
  logic [W-1:0]        mul_y_q;

  logic                found;
  logic [IdxW-1:0]     pick;
  logic [IdxW:0]       sum;
  logic [IdxW-1:0]     idx;
  logic [W-1:0]        sel_x;
  logic [W-1:0]        sel_y;
  logic [IdxW-1:0]     ptr_next;

  function automatic logic [NREQ-1:0] onehot(input logic [IdxW-1:0] i);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  // First requester at or after ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = (IdxW+1)'(ptr_q) + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NREQ)) begin
        sum = sum - (IdxW+1)'(NREQ);
      end
      idx = sum[IdxW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_x = bus.req_x[int'(pick)*W +: W];
    sel_y = bus.req_y[int'(pick)*W +: W];
  end

  always_comb begin
    ptr_next = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
    end else begin
      ack_q       <= '0;
      done_q      <= '0;
      mul_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            owner_q     <= pick;
            mul_x_q     <= sel_x;
            mul_y_q     <= sel_y;
            ack_q       <= onehot(pick);
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A valid landing on the timeout cycle still delivers the product.
          if (bus.mul_valid) begin
            result_q <= bus.mul_z;
            err_q    <= 1'b0;
            done_q   <= onehot(owner_q);
            state_q  <= StResp;
          end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= onehot(owner_q);
            state_q  <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StResp: begin
          ptr_q   <= ptr_next;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.mul_rst_n = ~rst;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural 9-cycle Booth multiplier plus a done scoreboard.
module tb_booth_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  typedef struct packed {
    logic [NREQ-1:0] who;
    logic [2*W-1:0]  res;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;
  int   last_ack_cyc = 0;
  int   last_done_cyc = 0;
  exp_t sb[$];
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: valid 9 cycles after the start cycle, or never when hang is set.
  int              mcnt = 0;
  logic [2*W-1:0]  mprod = '0;
  bit              hang = 1'b0;

  always @(posedge clk) begin
    if (!bus.mul_rst_n) begin
      mcnt <= 0;
    end else if (bus.mul_start) begin
      mcnt  <= 9;
      mprod <= $signed(bus.mul_x) * $signed(bus.mul_y);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign bus.mul_valid = (mcnt == 1) && !hang;
  assign bus.mul_z     = mprod;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ack != '0) begin
      last_ack_cyc = cyc;
      check_eq("start_with_ack", 32'(bus.mul_start), 32'd1);
    end
    if (!rst && bus.done != '0) begin
      n_done++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("done_owner", 32'(bus.done), 32'(e.who));
        check_eq("result", 32'(bus.result), 32'(e.res));
        check_eq("err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [NREQ-1:0] who, input logic [2*W-1:0] res,
                             input logic err);
    exp_t x;
    x.who = who;
    x.res = res;
    x.err = err;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
  endtask

  task automatic run(input int target, input bit drop_on_ack, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      tick();
      n++;
      if (drop_on_ack) bus.req = bus.req & ~bus.ack;
    end
    check_eq("run_bound", 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_ack(input logic [NREQ-1:0] who);
    int n = 0;
    while (bus.ack == '0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("ack_owner", 32'(bus.ack), 32'(who));
  endtask

  int req_cyc;
  int saved;

  initial begin
    bus.req   = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    do_reset();

    // Reset state
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_mul_x", 32'(bus.mul_x), 32'd0);
    check_eq("rst_start", 32'(bus.mul_start), 32'd0);

    // 1: single request, latency and signed product
    set_ops(1, 8'hF9, 8'h05);
    bus.req = 4'b0010;
    req_cyc = cyc;
    expect_done(4'b0010, 16'hFFDD, 1'b0);
    run(n_done + 1, 1'b1, 40);
    check_eq("t1_ack_lat", 32'(last_ack_cyc - req_cyc), 32'd1);
    check_eq("t1_done_lat", 32'(last_done_cyc - req_cyc), 32'd11);
    tick();

    // 2: all four at once, held until ack
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i * 3), 8'd2);
    bus.req = 4'b1111;
    expect_done(4'b0001, 16'h0000, 1'b0);
    expect_done(4'b0010, 16'h0006, 1'b0);
    expect_done(4'b0100, 16'h000C, 1'b0);
    expect_done(4'b1000, 16'h0012, 1'b0);
    run(n_done + 4, 1'b1, 200);
    tick();
    tick();

    // 3: req0 and req2 held continuously after owner 0 was last served
    do_reset();
    set_ops(0, 8'd1, 8'd1);
    bus.req = 4'b0001;
    expect_done(4'b0001, 16'h0001, 1'b0);
    run(n_done + 1, 1'b1, 40);
    tick();
    set_ops(0, 8'd4, 8'd5);
    set_ops(2, 8'hFD, 8'd7);
    bus.req = 4'b0101;
    expect_done(4'b0100, 16'hFFEB, 1'b0);
    expect_done(4'b0001, 16'h0014, 1'b0);
    expect_done(4'b0100, 16'hFFEB, 1'b0);
    expect_done(4'b0001, 16'h0014, 1'b0);
    run(n_done + 4, 1'b0, 200);
    bus.req = '0;
    tick();
    tick();
    check_eq("t3_idle", 32'(bus.busy), 32'd0);

    // 4: hung multiplier, watchdog abort
    do_reset();
    hang = 1'b1;
    set_ops(3, 8'd3, 8'd3);
    bus.req = 4'b1000;
    expect_done(4'b1000, 16'h0000, 1'b1);
    run(n_done + 1, 1'b1, 60);
    check_eq("t4_timeout_lat", 32'(last_done_cyc - last_ack_cyc), 32'd16);
    hang = 1'b0;

    // 5: operands held through WAIT despite requester changes
    do_reset();
    set_ops(1, 8'h7F, 8'h80);
    bus.req = 4'b0010;
    expect_done(4'b0010, 16'hC080, 1'b0);
    wait_ack(4'b0010);
    bus.req   = '0;
    bus.req_x = $urandom;
    bus.req_y = $urandom;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("t5_mul_x", 32'(bus.mul_x), 32'h7F);
      check_eq("t5_mul_y", 32'(bus.mul_y), 32'h80);
    end
    run(n_done + 1, 1'b0, 30);
    tick();

    // 6: reset mid-WAIT, then a normal transaction
    do_reset();
    set_ops(0, 8'h10, 8'h10);
    bus.req = 4'b0001;
    wait_ack(4'b0001);
    bus.req = '0;
    saved   = n_done;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check_eq("t6_no_done", 32'(n_done), 32'(saved));
    set_ops(2, 8'hF0, 8'h0C);
    bus.req = 4'b0100;
    expect_done(4'b0100, 16'hFF40, 1'b0);
    run(n_done + 1, 1'b1, 40);
    tick();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
